// File: rtl/mult_sequencer.sv
// mult_sequencer: step controller for the signed add-shift multiplier.
// Sequences clear, N add/shift steps and done handshaking per Run press.
module mult_sequencer #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             M,
    output logic             Clr_Ld,
    output logic             Clr_AX,
    output logic             Add,
    output logic             Sub,
    output logic             Shift_En,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             last_step;

    assign last_step = (step_q == LAST);

    // State and step counter registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state and step counter progression
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                step_d  = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_step) begin
                    step_d  = '0;
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                step_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath strobes; Clr_Ld is held off while reset is asserted
    always_comb begin
        Clr_Ld   = 1'b0;
        Clr_AX   = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        Step     = step_q;
        unique case (state_q)
            S_IDLE: begin
                Clr_Ld = Reset & ClearA_LoadB & ~Run;
            end
            S_START: begin
                Clr_AX = 1'b1;
                Busy   = 1'b1;
            end
            S_ADD: begin
                Add  = M;
                Sub  = M & last_step;
                Busy = 1'b1;
            end
            S_SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            S_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule
